// File: rtl/rtc_field_writer.sv
// rtc_field_writer
// Consumer side of the BCD field editor. Latches the editor's field code and
// value, validates the value when the operator leaves a field, keeps a shadow
// copy per field with a dirty bit, and drains dirty fields to the RTC bus
// controller one at a time over a req/ack handshake (lowest field code first).
//
// Build option: define FIELD_CLAMP_EN to clamp out-of-range (but BCD-valid)
// values to the field's min/max instead of rejecting them. Without the macro
// every out-of-range value is rejected with an err_o pulse.

module rtc_field_writer #(
  parameter int ADDR_W   = 8,
  parameter int N_FIELDS = 9
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic [3:0]        sel_i,
  input  logic [7:0]        val_i,
  output logic              wr_req_o,
  output logic [ADDR_W-1:0] wr_addr_o,
  output logic [7:0]        wr_data_o,
  input  logic              wr_ack_i,
  output logic              busy_o,
  output logic              err_o
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_REQ
  } state_t;

  // ---------------------------------------------------------------------
  // Field map: RTC register address and legal BCD range per field code.
  // ---------------------------------------------------------------------
  function automatic logic [7:0] field_addr(input logic [3:0] code);
    case (code)
      4'd1:    field_addr = 8'h21;
      4'd2:    field_addr = 8'h22;
      4'd3:    field_addr = 8'h23;
      4'd4:    field_addr = 8'h24;
      4'd5:    field_addr = 8'h25;
      4'd6:    field_addr = 8'h26;
      4'd7:    field_addr = 8'h43;
      4'd8:    field_addr = 8'h42;
      4'd9:    field_addr = 8'h41;
      default: field_addr = 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] field_min(input logic [3:0] code);
    case (code)
      4'd4, 4'd5: field_min = 8'h01;
      default:    field_min = 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] field_max(input logic [3:0] code);
    case (code)
      4'd1, 4'd2, 4'd8, 4'd9: field_max = 8'h59;
      4'd3, 4'd7:             field_max = 8'h23;
      4'd4:                   field_max = 8'h31;
      4'd5:                   field_max = 8'h12;
      4'd6:                   field_max = 8'h99;
      default:                field_max = 8'h00;
    endcase
  endfunction

  // ---------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------
  state_t              state_q, state_d;
  logic [3:0]          sel_q, sel_d;
  logic [7:0]          val_q, val_d;
  logic [N_FIELDS:1]   dirty_q, dirty_d;
  logic [7:0]          shadow_q [1:N_FIELDS];
  logic [7:0]          shadow_d [1:N_FIELDS];
  logic [3:0]          cur_idx_q, cur_idx_d;
  logic                recommit_q, recommit_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [7:0]          wr_data_q, wr_data_d;
  logic                err_q, err_d;

  // Commit / validation signals
  logic                commit;
  logic                nib_ok;
  logic                in_range;
  logic                accept;
  logic                reject;
  logic [7:0]          fmin;
  logic [7:0]          fmax;
  logic [7:0]          commit_val;

  // Scheduler signals
  logic [3:0]          pick_idx;
  logic [7:0]          pick_data;
  logic [3:0]          flight_idx;
  logic                ack_take;

  // Input capture: codes outside 1..N_FIELDS are folded to 0 (idle).
  always_comb begin
    sel_d = 4'd0;
    if (sel_i != 4'd0 && sel_i <= 4'(N_FIELDS)) begin
      sel_d = sel_i;
    end
    val_d = val_i;
  end

  // Commit detection and range check of the value held for the field being left.
  always_comb begin
    commit   = (sel_q != 4'd0) && (sel_d != sel_q);
    fmin     = field_min(sel_q);
    fmax     = field_max(sel_q);
    nib_ok   = (val_q[7:4] <= 4'd9) && (val_q[3:0] <= 4'd9);
    in_range = (val_q >= fmin) && (val_q <= fmax);
`ifdef FIELD_CLAMP_EN
    accept     = commit && nib_ok;
    reject     = commit && !nib_ok;
    commit_val = in_range ? val_q : ((val_q > fmax) ? fmax : fmin);
`else
    accept     = commit && nib_ok && in_range;
    reject     = commit && !(nib_ok && in_range);
    commit_val = val_q;
`endif
    err_d = reject;
  end

  // Lowest-numbered dirty field is serviced next.
  always_comb begin
    pick_idx  = 4'd0;
    pick_data = 8'h00;
    for (int i = N_FIELDS; i >= 1; i--) begin
      if (dirty_q[i]) begin
        pick_idx  = 4'(i);
        pick_data = shadow_q[i];
      end
    end
  end

  // The field currently being written: chosen in LOAD, latched for REQ.
  always_comb begin
    flight_idx = (state_q == ST_LOAD) ? pick_idx : cur_idx_q;
    ack_take   = (state_q == ST_REQ) && wr_ack_i;
  end

  // Remember a re-commit to the in-flight field so its dirty bit survives the ack.
  always_comb begin
    recommit_d = recommit_q;
    if (accept && state_q != ST_IDLE && sel_q == flight_idx) begin
      recommit_d = 1'b1;
    end
    if (state_q == ST_IDLE || ack_take) begin
      recommit_d = 1'b0;
    end
  end

  // Per-field shadow and dirty next-state; a fresh commit always wins over the ack clear.
  generate
    for (genvar gi = 1; gi <= N_FIELDS; gi++) begin : g_field
      logic hit;
      logic clr;
      assign hit            = accept && (sel_q == 4'(gi));
      assign clr            = ack_take && (cur_idx_q == 4'(gi)) && !recommit_q;
      assign shadow_d[gi]   = hit ? commit_val : shadow_q[gi];
      assign dirty_d[gi]    = hit ? 1'b1 : (clr ? 1'b0 : dirty_q[gi]);
    end
  endgenerate

  // Write scheduler next-state and bus register loads.
  always_comb begin
    state_d   = state_q;
    cur_idx_d = cur_idx_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    case (state_q)
      ST_IDLE: begin
        if (dirty_q != '0) begin
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        cur_idx_d = pick_idx;
        wr_addr_d = ADDR_W'(field_addr(pick_idx));
        wr_data_d = pick_data;
        state_d   = ST_REQ;
      end
      ST_REQ: begin
        if (wr_ack_i) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // All registers; reset drops the request at once and discards pending work.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= ST_IDLE;
      sel_q      <= 4'd0;
      val_q      <= 8'h00;
      dirty_q    <= '0;
      cur_idx_q  <= 4'd0;
      recommit_q <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= 8'h00;
      err_q      <= 1'b0;
      for (int i = 1; i <= N_FIELDS; i++) begin
        shadow_q[i] <= 8'h00;
      end
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      val_q      <= val_d;
      dirty_q    <= dirty_d;
      cur_idx_q  <= cur_idx_d;
      recommit_q <= recommit_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      err_q      <= err_d;
      shadow_q   <= shadow_d;
    end
  end

  // Outputs
  assign wr_req_o  = (state_q == ST_REQ);
  assign wr_addr_o = wr_addr_q;
  assign wr_data_o = wr_data_q;
  assign busy_o    = (dirty_q != '0) || (state_q != ST_IDLE);
  assign err_o     = err_q;

endmodule
